counter_chain_sched: RTL and testbench
======================================

COUNTER_CHAIN_SCHED -- requirements
Module: counter_chain_sched

Interface
REQ-001 Parameter OUTREG, default "FALSE"; "TRUE" adds one register stage on the result outputs.
REQ-002 Parameter IN_W, default 64; operand width; a multiple of SLICE_W.
REQ-003 Parameter SLICE_W, default 8; bits compressed per cycle.
REQ-004 clk  input  1  rising-edge clock.
REQ-005 rst_n  input  1  reset, asynchronous assert, active-low.
REQ-006 in_valid  input  1  operand offered.
REQ-007 in_ready  output  1  controller accepts an operand this cycle.
REQ-008 in_data  input  IN_W  operand whose set bits are counted.
REQ-009 out_valid  output  1  result held stable.
REQ-010 out_ready  input  1  consumer accepts the result.
REQ-011 out_count  output  $clog2(IN_W)+1  population count of the accepted operand.
REQ-012 busy  output  1  high in any state other than IDLE.

Function
REQ-013 The block SHALL implement a three-state FSM: IDLE, RUN, HOLD.
REQ-014 IDLE: in_ready=1; in_valid=1 SHALL capture in_data into the shadow register, clear the accumulator, clear slice index to 0, and go to RUN.
REQ-015 RUN: each cycle SHALL add popcount(shadow[idx*SLICE_W +: SLICE_W]) to the accumulator and increment idx.
REQ-016 RUN SHALL go to HOLD in the cycle in which slice idx = IN_W/SLICE_W-1 is added, with no extra cycle.
REQ-017 HOLD: out_valid=1 and out_count=accumulator; out_ready=1 SHALL return the FSM to IDLE.
REQ-018 With OUTREG="FALSE", latency from the accept edge to out_valid SHALL be IN_W/SLICE_W cycles (8 for defaults).
REQ-019 With OUTREG="TRUE", latency SHALL be IN_W/SLICE_W+1 cycles. out_valid and out_count SHALL be registered together.
REQ-020 in_ready SHALL be 0 in RUN and HOLD. An operand offered then SHALL NOT be captured.
REQ-021 out_count and out_valid SHALL NOT change while out_valid=1 and out_ready=0, for any duration of backpressure.
REQ-022 The accumulator SHALL be $clog2(IN_W)+1 bits wide and SHALL never wrap; all-ones input yields exactly IN_W.
REQ-023 in_valid arriving in the same cycle as the HOLD->IDLE handshake SHALL NOT be accepted; acceptance starts the following cycle.
REQ-024 Throughput SHALL be one operand per IN_W/SLICE_W+2 cycles under continuous valid/ready.
REQ-025 in_data SHALL be sampled only at the accept edge; later changes SHALL NOT affect the result.

Reset
REQ-026 On rst_n=0 the block SHALL asynchronously set FSM=IDLE, idx=0, accumulator=0, shadow=0, out_valid=0, out_count=0, and busy=0.
REQ-027 After reset, in_ready SHALL be 1.
REQ-028 Reset asserted mid-RUN or mid-HOLD SHALL discard the operation; no result SHALL be emitted after release.
REQ-029 The first accept SHALL occur no earlier than the first rising edge with rst_n=1.

Configuration
REQ-030 Macro COUNTER_CHAIN_SCHED_THRESH_EN SHALL control a threshold feature.
REQ-031 With COUNTER_CHAIN_SCHED_THRESH_EN defined, the block SHALL add input thresh ($clog2(IN_W)+1 bits) and output out_ge (1 bit).
REQ-032 thresh SHALL be sampled together with in_data at the accept edge.
REQ-033 out_ge SHALL equal (out_count >= thresh) and SHALL be valid with out_valid. out_ge SHALL reset to 0.
REQ-034 Without COUNTER_CHAIN_SCHED_THRESH_EN, thresh and out_ge SHALL NOT exist, and the timing of all other outputs SHALL be identical.

Structure
REQ-035 Shared package counter_pkg SHALL hold the FSM state enum (IDLE, RUN, HOLD) and the function for the count width ($clog2(w)+1).
REQ-036 The per-slice popcount SHALL be one sub-module, slice_counter, which is combinational and has a SLICE_W input and a $clog2(SLICE_W)+1 output.
REQ-037 slice_counter is the point where a generalized-counter chain can be substituted; its port contract SHALL NOT change when that happens.

Verification
REQ-038 Defaults, OUTREG="FALSE", in_data=64'h0 accepted, out_ready=1: out_valid SHALL rise after 8 cycles with out_count=0.
REQ-039 in_data=64'hFFFF_FFFF_FFFF_FFFF: out_count=64 (7'b1000000), with no wrap.
REQ-040 in_data=64'h8000_0000_0000_0001, out_ready held 0 for 20 cycles: out_count SHALL stay 2, out_valid SHALL stay 1, and in_ready SHALL stay 0 throughout.
REQ-041 rst_n pulsed low at cycle 4 of RUN with in_data=64'hFF: no out_valid SHALL appear, in_ready=1 after release, and the next operand 64'h3 SHALL yield 2.
REQ-042 OUTREG="TRUE", in_data=64'h0F0F_0F0F_0F0F_0F0F: out_count=32 after 9 cycles. Back-to-back operands SHALL be accepted every 11 cycles.
REQ-043 THRESH_EN defined, in_data=64'hFF with thresh=8: out_ge=1. The same in_data with thresh=9: out_ge=0.

Source files
------------

// File: rtl/counter_chain_sched_pkg.sv
// counter_pkg: FSM state encoding and count-width helper shared by the popcount scheduler.
package counter_pkg;
  typedef enum logic [1:0] {IDLE, RUN, HOLD} state_t;
  function automatic int cnt_w(input int w);
    return $clog2(w) + 1;
  endfunction
endpackage

// File: rtl/counter_chain_sched_slice_counter.sv
// slice_counter: combinational popcount of one slice; swap point for a generalized-counter chain.
module slice_counter import counter_pkg::*; #(
  parameter int SLICE_W = 8
) (
  input  logic [SLICE_W-1:0]       bits,
  output logic [$clog2(SLICE_W):0] count
);
  localparam int CW = cnt_w(SLICE_W);
  always_comb begin
    count = '0;
    for (int i = 0; i < SLICE_W; i++) count = count + CW'(bits[i]);
  end
endmodule

// File: rtl/counter_chain_sched.sv
// counter_chain_sched: sliced popcount with valid/ready handshakes, one slice per cycle.
// Optional threshold compare enabled by defining COUNTER_CHAIN_SCHED_THRESH_EN.
module counter_chain_sched import counter_pkg::*; #(
  parameter string OUTREG  = "FALSE",
  parameter int    IN_W    = 64,
  parameter int    SLICE_W = 8
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  in_valid,
  output logic                  in_ready,
  input  logic [IN_W-1:0]       in_data,
  output logic                  out_valid,
  input  logic                  out_ready,
  output logic [$clog2(IN_W):0] out_count,
  output logic                  busy
`ifdef COUNTER_CHAIN_SCHED_THRESH_EN
  ,
  input  logic [$clog2(IN_W):0] thresh,
  output logic                  out_ge
`endif
);
  localparam int N  = IN_W / SLICE_W;
  localparam int CW = cnt_w(IN_W);
  localparam int SW = cnt_w(SLICE_W);
  localparam int XW = cnt_w(N);
  state_t state, state_nx;
  logic [XW-1:0] idx;
  logic [CW-1:0] acc;
  logic [IN_W-1:0] shadow;
  logic [SW-1:0] slice_cnt;
  logic accept, last, done;
  slice_counter #(.SLICE_W(SLICE_W)) u_slice (
    .bits  (shadow[idx*SLICE_W +: SLICE_W]),
    .count (slice_cnt)
  );
  assign in_ready = state == IDLE;
  assign busy     = state != IDLE;
  assign accept   = in_ready && in_valid;
  assign last     = idx == XW'(N - 1);
  assign done     = out_valid && out_ready;
  always_comb begin
    state_nx = state == IDLE ? (in_valid ? RUN : IDLE) :
               state == RUN  ? (last ? HOLD : RUN) :
                               (done ? IDLE : HOLD);
  end
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state  <= IDLE;
      idx    <= '0;
      acc    <= '0;
      shadow <= '0;
    end else begin
      state <= state_nx;
      if (accept) begin
        shadow <= in_data;
        acc    <= '0;
        idx    <= '0;
      end else if (state == RUN) begin
        acc <= acc + CW'(slice_cnt);
        idx <= idx + XW'(1);
      end
    end
  end
  generate
    if (OUTREG == "TRUE") begin : g_reg
      // HOLD persists until the registered valid is consumed, adding exactly one cycle.
      always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
          out_valid <= 1'b0;
          out_count <= '0;
        end else begin
          out_valid <= state == HOLD && !done;
          out_count <= acc;
        end
      end
    end else begin : g_comb
      assign out_valid = state == HOLD;
      assign out_count = acc;
    end
  endgenerate
`ifdef COUNTER_CHAIN_SCHED_THRESH_EN
  logic [CW-1:0] thresh_r;
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) thresh_r <= '0;
    else if (accept) thresh_r <= thresh;
  end
  assign out_ge = out_valid && out_count >= thresh_r;
`endif
endmodule

// File: tb/tb_counter_chain_sched.sv
// tb_counter_chain_sched: directed checks of latency, backpressure, reset and OUTREG timing.
module tb_counter_chain_sched;
  logic clk = 1'b0, rst_n = 1'b0, in_valid = 1'b0, out_ready = 1'b1;
  logic [63:0] in_data = '0;
  logic in_ready, out_valid, busy, r_in_ready, r_out_valid, r_busy;
  logic [6:0] out_count, r_out_count;
`ifdef COUNTER_CHAIN_SCHED_THRESH_EN
  logic [6:0] thresh = '0;
  logic out_ge, r_out_ge;
`endif
  int total = 0, bad = 0;
  always #5 clk = ~clk;
  counter_chain_sched #(.OUTREG("FALSE")) dut (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready), .in_data(in_data),
    .out_valid(out_valid), .out_ready(out_ready), .out_count(out_count), .busy(busy)
`ifdef COUNTER_CHAIN_SCHED_THRESH_EN
    , .thresh(thresh), .out_ge(out_ge)
`endif
  );
  counter_chain_sched #(.OUTREG("TRUE")) dut_r (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(r_in_ready), .in_data(in_data),
    .out_valid(r_out_valid), .out_ready(out_ready), .out_count(r_out_count), .busy(r_busy)
`ifdef COUNTER_CHAIN_SCHED_THRESH_EN
    , .thresh(thresh), .out_ge(r_out_ge)
`endif
  );
  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask
  task automatic tick();
    @(posedge clk);
    #1;
  endtask
  task automatic offer(input logic [63:0] d);
    in_valid = 1'b1;
    in_data  = d;
    tick();
    in_valid = 1'b0;
  endtask
  task automatic wait_out(input bit r, output int n);
    n = 0;
    do begin
      tick();
      n++;
    end while (!(r ? r_out_valid : out_valid) && n < 40);
  endtask
  task automatic run_op(input string tag, input bit r, input logic [63:0] d, input int lat, input logic [6:0] cnt);
    int n;
    offer(d);
    wait_out(r, n);
    check({tag, "_lat"}, 64'(n), 64'(lat));
    check({tag, "_cnt"}, r ? r_out_count : out_count, cnt);
    tick();
    check({tag, "_ready"}, r ? r_in_ready : in_ready, 1);
    repeat (3) tick();
  endtask
  initial begin
    int n, seen;
    int a0[$], a1[$];
    #12;
    check("rst_valid", out_valid, 0);
    check("rst_ready", in_ready, 1);
    check("rst_busy", busy, 0);
    check("rst_count", out_count, 0);
    check("rst_r_valid", r_out_valid, 0);
    rst_n = 1'b1;
    tick();
    run_op("zero", 0, 64'h0, 8, 7'd0);
    run_op("ones", 0, 64'hFFFF_FFFF_FFFF_FFFF, 8, 7'd64);
    out_ready = 1'b0;
    offer(64'h8000_0000_0000_0001);
    wait_out(0, n);
    check("bp_lat", 64'(n), 8);
    in_valid = 1'b1;
    in_data  = 64'hFFFF_FFFF_FFFF_FFFF;
    repeat (20) begin
      check("bp_count", out_count, 2);
      check("bp_valid", out_valid, 1);
      check("bp_ready", in_ready, 0);
      tick();
    end
    out_ready = 1'b1;
    in_data   = 64'h7;
    tick();
    check("hs_ready", in_ready, 1);
    check("hs_busy", busy, 0);
    tick();
    in_valid = 1'b0;
    in_data  = 64'hFFFF_FFFF_FFFF_FFFF;
    check("late_busy", busy, 1);
    wait_out(0, n);
    check("late_lat", 64'(n), 8);
    check("late_cnt", out_count, 3);
    repeat (4) tick();
    offer(64'hFF);
    repeat (3) tick();
    rst_n = 1'b0;
    #1;
    check("mid_rst_busy", busy, 0);
    check("mid_rst_valid", out_valid, 0);
    check("mid_rst_r_busy", r_busy, 0);
    #2;
    rst_n = 1'b1;
    seen = 0;
    repeat (12) begin
      tick();
      if (out_valid || r_out_valid) seen++;
    end
    check("mid_rst_no_out", 64'(seen), 0);
    check("mid_rst_ready", in_ready, 1);
    run_op("after_rst", 0, 64'h3, 8, 7'd2);
    run_op("oreg", 1, 64'h0F0F_0F0F_0F0F_0F0F, 9, 7'd32);
    in_valid = 1'b1;
    in_data  = 64'h1;
    for (int c = 0; c < 40; c++) begin
      if (in_ready) a0.push_back(c);
      if (r_in_ready) a1.push_back(c);
      tick();
    end
    in_valid = 1'b0;
    check("b2b_n0", 64'(a0.size()), 4);
    check("b2b_n1", 64'(a1.size()), 4);
    check("b2b_p0a", 64'(a0[1] - a0[0]), 10);
    check("b2b_p0b", 64'(a0[2] - a0[1]), 10);
    check("b2b_p1a", 64'(a1[1] - a1[0]), 11);
    check("b2b_p1b", 64'(a1[2] - a1[1]), 11);
    repeat (15) tick();
`ifdef COUNTER_CHAIN_SCHED_THRESH_EN
    thresh = 7'd8;
    offer(64'hFF);
    thresh = 7'd0;
    wait_out(0, n);
    check("ge_eq", out_ge, 1);
    tick();
    check("ge_r_eq", r_out_ge, 1);
    repeat (4) tick();
    thresh = 7'd9;
    offer(64'hFF);
    thresh = 7'd0;
    wait_out(0, n);
    check("ge_above", out_ge, 0);
    check("ge_cnt", out_count, 8);
    repeat (4) tick();
`endif
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
